// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: memory-op encodings
// (func3), FSM state encoding, byte-strobe constants and request-legality
// helpers. Decode uses the same encodings.
package lsu_pkg;

    // Memory operation encodings (func3 of loads/stores)
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    // Byte-strobe patterns before lane shifting
    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_B    = 4'b0001;
    localparam logic [3:0] STRB_H    = 4'b0011;
    localparam logic [3:0] STRB_W    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_e;

    // Stores only exist as B/H/W; loads additionally allow BU/HU.
    function automatic logic op_legal(input logic wen, input logic [2:0] op);
        logic ok;
        case (op)
            MEM_B, MEM_H, MEM_W: ok = 1'b1;
            MEM_BU, MEM_HU:      ok = ~wen;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Natural-alignment violation for halfword and word accesses.
    function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic mis;
        case (op)
            MEM_H, MEM_HU: mis = off[0];
            MEM_W:         mis = (off != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic for the load/store unit: store data replication and
// write-strobe generation, load byte/halfword extraction and sign/zero
// extension. Purely combinational; the lane datapath is fixed at 32 bits.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] store_data,
    output logic [31:0] store_word,
    output logic [3:0]  store_strb,
    input  logic [31:0] load_word,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Replicate store data across all lanes and shift strobes to the addressed lane
    always_comb begin
        store_word = 32'h0000_0000;
        store_strb = STRB_NONE;
        case (op)
            MEM_B: begin
                store_word = {4{store_data[7:0]}};
                store_strb = STRB_B << byte_off;
            end
            MEM_H: begin
                store_word = {2{store_data[15:0]}};
                store_strb = STRB_H << {byte_off[1], 1'b0};
            end
            MEM_W: begin
                store_word = store_data;
                store_strb = STRB_W;
            end
            default: begin
                store_word = 32'h0000_0000;
                store_strb = STRB_NONE;
            end
        endcase
    end

    // Pick the addressed byte/halfword of the read word and extend it
    always_comb begin
        byte_s = 8'h00;
        case (byte_off)
            2'd0:    byte_s = load_word[7:0];
            2'd1:    byte_s = load_word[15:8];
            2'd2:    byte_s = load_word[23:16];
            2'd3:    byte_s = load_word[31:24];
            default: byte_s = load_word[7:0];
        endcase
        half_s = byte_off[1] ? load_word[31:16] : load_word[15:0];
        case (op)
            MEM_B:   load_data = {{24{byte_s[7]}}, byte_s};
            MEM_H:   load_data = {{16{half_s[15]}}, half_s};
            MEM_W:   load_data = load_word;
            MEM_BU:  load_data = {24'h00_0000, byte_s};
            MEM_HU:  load_data = {16'h0000, half_s};
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit. Accepts one access at a time from the core,
// issues a single word-aligned bus transaction, and returns extended load
// data (or zero for stores) with an error flag.
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned
// halfword/word accesses with an error response and no bus transaction;
// without it the low address bits are simply truncated.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rerr
);

    lsu_state_e        state_r;
    lsu_state_e        state_s;
    logic              wen_r;
    logic [2:0]        op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata_r;
    logic              err_r;
    logic              accept_s;
    logic              req_bad_s;
    logic [DATA_W-1:0] lane_wdata_s;
    logic [DATA_W-1:0] lane_rdata_s;
    logic [3:0]        lane_strb_s;

    lsu_lane u_lane (
        .op         (op_r),
        .byte_off   (addr_r[1:0]),
        .store_data (wdata_r),
        .store_word (lane_wdata_s),
        .store_strb (lane_strb_s),
        .load_word  (mem_rdata),
        .load_data  (lane_rdata_s)
    );

    // Decide whether an incoming request goes straight to an error response
    always_comb begin
        accept_s = (state_r == ST_IDLE) & req_valid;
`ifdef LSU_MISALIGN_CHECK_EN
        req_bad_s = ~op_legal(req_wen, req_op) | op_misaligned(req_op, req_addr[1:0]);
`else
        req_bad_s = ~op_legal(req_wen, req_op);
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: one access in flight, bad requests skip the bus
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_s = req_bad_s ? ST_RESP : ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Latch the accepted request and capture the response payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_r   <= 1'b0;
            op_r    <= 3'b000;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            rdata_r <= {DATA_W{1'b0}};
            err_r   <= 1'b0;
        end else if (accept_s) begin
            wen_r   <= req_wen;
            op_r    <= req_op;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            rdata_r <= {DATA_W{1'b0}};
            err_r   <= req_bad_s;
        end else if ((state_r == ST_WAIT) && mem_rvalid) begin
            err_r   <= mem_rerr;
            rdata_r <= (wen_r | mem_rerr) ? {DATA_W{1'b0}} : lane_rdata_s;
        end else if ((state_r == ST_RESP) && rsp_ready) begin
            err_r   <= 1'b0;
            rdata_r <= {DATA_W{1'b0}};
        end else begin
            err_r   <= err_r;
            rdata_r <= rdata_r;
        end
    end

    // Outputs decoded from registered state; bus fields are zero outside REQ
    always_comb begin
        req_ready = (state_r == ST_IDLE);
        rsp_valid = (state_r == ST_RESP);
        rsp_rdata = rdata_r;
        rsp_err   = err_r;
        if (state_r == ST_REQ) begin
            mem_valid = 1'b1;
            mem_wen   = wen_r;
            mem_addr  = {addr_r[ADDR_W-1:2], 2'b00};
            if (wen_r) begin
                mem_wdata = lane_wdata_s;
                mem_wstrb = lane_strb_s;
            end else begin
                mem_wdata = {DATA_W{1'b0}};
                mem_wstrb = STRB_NONE;
            end
        end else begin
            mem_valid = 1'b0;
            mem_wen   = 1'b0;
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = {DATA_W{1'b0}};
            mem_wstrb = STRB_NONE;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard testbench for the load/store unit. The driver computes the
// expected bus request and response from a behavioural model and queues
// them; a monitor on the falling edge compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rerr;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_rerr   (mem_rerr)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: access size and alignment rules in plain arithmetic
    function automatic void model(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rword, input logic rerr,
                                  output logic bad, output bus_t b, output rsp_t r);
        int          size;
        int          off;
        logic [31:0] v;
        if (wen) bad = !(op inside {3'd0, 3'd1, 3'd2});
        else     bad = !(op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size = 1 << op[1:0];
`ifdef LSU_MISALIGN_CHECK_EN
        if (!bad && (addr % size) != 0) bad = 1'b1;
`endif
        off     = int'(addr % 4) - (int'(addr % 4) % size);
        b.addr  = addr & 32'hFFFF_FFFC;
        b.wen   = wen;
        b.strb  = 4'b0000;
        b.wdata = 32'h0;
        if (wen) begin
            b.strb = 4'(((1 << size) - 1) << off);
            if (size == 1)      b.wdata = (wdata & 32'hFF) * 32'h0101_0101;
            else if (size == 2) b.wdata = (wdata & 32'hFFFF) * 32'h0001_0001;
            else                b.wdata = wdata;
        end
        v = rword >> (off * 8);
        if (size == 1) begin
            v = v & 32'hFF;
            if (!op[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2) begin
            v = v & 32'hFFFF;
            if (!op[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        r.err   = bad | rerr;
        r.rdata = (r.err || wen) ? 32'h0 : v;
    endfunction

    // Monitor: compare presented bus request / response with queue heads
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rsp_valid_req_ready_excl", 32'(rsp_valid & req_ready), 32'd0);
            if (mem_valid) begin
                if (bus_q.size() == 0) begin
                    chk("spurious_mem_valid", 32'(mem_valid), 32'd0);
                end else begin
                    chk("mem_addr", mem_addr, bus_q[0].addr);
                    chk("mem_wen", 32'(mem_wen), 32'(bus_q[0].wen));
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(bus_q[0].strb));
                    if (bus_q[0].wen) chk("mem_wdata", mem_wdata, bus_q[0].wdata);
                    if (mem_ready) void'(bus_q.pop_front());
                end
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("spurious_rsp_valid", 32'(rsp_valid), 32'd0);
                end else begin
                    chk("rsp_rdata", rsp_rdata, rsp_q[0].rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(rsp_q[0].err));
                    if (rsp_ready) void'(rsp_q.pop_front());
                end
            end
        end
    end

    // One complete access; called at posedge+#1 with the DUT idle
    task automatic access(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rword, input logic rerr,
                          input int rdy_dly, input int rv_dly, input int rsp_dly);
        logic bad;
        bus_t b;
        rsp_t r;
        int   lat;
        int   exp_lat;
        model(wen, op, addr, wdata, rword, rerr, bad, b, r);
        if (!bad) bus_q.push_back(b);
        rsp_q.push_back(r);
        exp_lat = bad ? 0 : 2 + rdy_dly + rv_dly;
        req_valid = 1'b1;
        req_wen   = wen;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        fork
            begin
                if (!bad) begin
                    repeat (rdy_dly) begin @(posedge clk); #1; end
                    mem_ready = 1'b1;
                    @(posedge clk); #1;
                    mem_ready = 1'b0;
                    repeat (rv_dly) begin @(posedge clk); #1; end
                    mem_rvalid = 1'b1;
                    mem_rdata  = rword;
                    mem_rerr   = rerr;
                    @(posedge clk); #1;
                    mem_rvalid = 1'b0;
                    mem_rerr   = 1'b0;
                    mem_rdata  = $urandom;
                end
            end
            begin
                lat = 0;
                while (!rsp_valid && lat < 64) begin @(posedge clk); #1; lat++; end
                chk("latency", 32'(lat), 32'(exp_lat));
                if (rsp_valid) begin
                    repeat (rsp_dly) begin @(posedge clk); #1; end
                    rsp_ready = 1'b1;
                    @(posedge clk); #1;
                    rsp_ready = 1'b0;
                    chk("req_ready_after_rsp", 32'(req_ready), 32'd1);
                end else begin
                    rsp_q.delete();
                    bus_q.delete();
                end
            end
        join
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_op     = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        mem_rerr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_mem_valid", 32'(mem_valid), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases from the test plan
        access(1'b0, 3'b000, 32'h8000_0003, 32'h0,         32'h80FF_0000, 1'b0, 0, 0, 0);
        access(1'b0, 3'b101, 32'h0000_0102, 32'h0,         32'hBEEF_1234, 1'b0, 0, 0, 0);
        access(1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'hBEEF_1234, 1'b0, 1, 0, 0);
        access(1'b1, 3'b000, 32'h0000_0201, 32'h1234_56AB, 32'h0,         1'b0, 0, 1, 0);
        access(1'b1, 3'b001, 32'h0000_0202, 32'h0000_CAFE, 32'h0,         1'b0, 0, 0, 1);
        access(1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'h1357_9BDF, 1'b1, 4, 1, 2);
        access(1'b0, 3'b011, 32'h0000_0010, 32'h0,         32'h0,         1'b0, 0, 0, 0);
        access(1'b0, 3'b010, 32'h0000_0002, 32'h0,         32'hA5A5_0F0F, 1'b0, 0, 0, 0);
        access(1'b1, 3'b100, 32'h0000_0300, 32'hFFFF_FFFF, 32'h0,         1'b0, 0, 0, 0);
        access(1'b1, 3'b010, 32'h0000_0307, 32'hDEAD_BEEF, 32'h0,         1'b0, 0, 0, 0);

        // Reset while waiting for read data; the late completion must be ignored
        bus_q.push_back('{addr: 32'h0000_0040, wen: 1'b0, strb: 4'b0000, wdata: 32'h0});
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_op    = 3'b010;
        req_addr  = 32'h0000_0040;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_wait_req_ready", 32'(req_ready), 32'd1);
        chk("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_wait_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_wait_mem_addr", mem_addr, 32'd0);
        chk("rst_wait_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_wait_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        repeat (3) begin
            chk("late_rvalid_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("late_rvalid_req_ready", 32'(req_ready), 32'd1);
            @(posedge clk); #1;
        end

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   1'($urandom_range(0, 9) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV32I core. Consumes the per-instruction memory controls produced at decode (3-bit memory op = func3, memory write enable) plus the ALU-computed address and rs2 data. Performs one access at a time over a valid/ready memory port, handling byte-lane steering, write strobes and load sign/zero extension. Sits between execute and write-back; the core stalls on `req_ready`/`rsp_valid`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; fixed at 32 for RV32I lane logic
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  core presents an access
- `req_ready`  out  1  LSU accepts; high only in IDLE
- `req_wen`  in  1  1 = store, 0 = load
- `req_op`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  DATA_W  store data, right-aligned
- `rsp_valid`  out  1  access complete
- `rsp_ready`  in  1  core consumes response
- `rsp_rdata`  out  DATA_W  extended load data; 0 for stores
- `rsp_err`  out  1  bus error, illegal op, or misalign (see Configuration)
- `mem_valid`  out  1  bus request
- `mem_ready`  in  1  bus accepts request
- `mem_wen`  out  1  write request
- `mem_addr`  out  ADDR_W  word-aligned address (`req_addr` with [1:0] = 0)
- `mem_wdata`  out  DATA_W  lane-replicated store data
- `mem_wstrb`  out  4  byte enables; 0000 for loads
- `mem_rvalid`  in  1  completion (read data or write ack)
- `mem_rdata`  in  DATA_W  read word
- `mem_rerr`  in  1  bus error, qualified by `mem_rvalid`

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`: latch wen/op/addr/wdata. Legal → REQ. Illegal (load op 011/110/111; store op other than 000/001/010) → RESP with `rsp_err`=1, no bus transaction.
- REQ: `mem_*` driven from latched request, stable until `mem_ready`; then → WAIT.
- WAIT: on `mem_rvalid` → RESP; latch `rsp_err`=`mem_rerr`; loads capture extended data. `mem_rvalid` outside WAIT ignored.
- RESP: `rsp_valid`=1, data/err stable until `rsp_ready`; then → IDLE.
- Store lanes: B → `wdata[7:0]` replicated ×4, `wstrb`=0001<<addr[1:0]; H → `wdata[15:0]` ×2, `wstrb`=0011<<(2·addr[1]); W → 1111.
- Load extract: B/BU byte at addr[1:0]·8; H/HU half at addr[1]·16; B/H sign-extend, BU/HU zero-extend; W unchanged.
- Without misalign checking, H ignores addr[0], W ignores addr[1:0].
- Error response with `rsp_rdata`=0.

## Timing
- Reset (async, any state): IDLE; `req_ready`=1; all other outputs 0; latched request cleared. In-flight bus transaction abandoned; late `mem_rvalid` ignored.
- Accept at edge E0 → `mem_valid` high in cycle after E0 (registered).
- Min load/store latency: `mem_ready` at E1, `mem_rvalid` at E2 → `rsp_valid` high after E2; 3 cycles accept-to-response.
- Illegal/misaligned: `rsp_valid` in cycle after E0.
- `mem_rvalid` may not precede the `mem_ready` handshake; sampled from the edge after it.
- `rsp_valid` and `req_ready` never both high; back-to-back accept in the cycle after `rsp_ready` handshake.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: H/HU with addr[0]=1, or W with addr[1:0]≠00, → RESP with `rsp_err`=1, `rsp_rdata`=0, no bus transaction.
- Undefined: no check; low address bits truncated as in Operation; no misalign error path synthesized.

## Structure
- `lsu_pkg`: memory-op encodings (`MEM_B`, `MEM_H`, `MEM_W`, `MEM_BU`, `MEM_HU`), state enum, strobe constants; shared with decode.
- Sub-module `lsu_lane`: combinational store replication/strobe generation and load extract/extend; FSM stays in `lsu`.

## Test plan
- LB addr 0x8000_0003, `mem_rdata`=0x80FF_0000 → `mem_addr`=0x8000_0000, `wstrb`=0000, `rsp_rdata`=0xFFFF_FF80, 3-cycle latency.
- LHU addr 0x102, `mem_rdata`=0xBEEF_1234 → `rsp_rdata`=0x0000_BEEF; LH same → 0xFFFF_BEEF.
- SB addr 0x201, wdata 0x1234_56AB → `mem_wdata`=0xABAB_ABAB, `wstrb`=0010; SH addr 0x202, wdata 0x0000_CAFE → 0xCAFE_CAFE, 1100.
- `mem_ready` low 4 cycles, `mem_rvalid` with `mem_rerr`=1; `rsp_ready` low 2 cycles → request held stable, `rsp_valid` held, `rsp_err`=1, `rsp_rdata`=0.
- Load op 011 → `rsp_err`=1 next cycle, `mem_valid` never asserted; with macro, LW addr 0x2 → same; without, `mem_addr`=0x0, normal access.
- `rst_n` low during WAIT, later `mem_rvalid` → IDLE, outputs 0, no spurious `rsp_valid`.
